// File: rtl/cnt161_pkg.sv
// Shared definitions for the cnt161 timer: controller state encoding and slice width.
package cnt161_pkg;

  localparam int SLICE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    HOLD = 2'd3
  } state_e;

endpackage

// File: rtl/cnt161_timer_ctrl_if.sv
// Control/status bundle between register logic and cnt161_timer_ctrl.
// The gate input exists only when CNT_GATE_EN is defined.
interface cnt161_timer_ctrl_if #(
  parameter int W = 8
);

`ifdef CNT_GATE_EN
  logic         gate;
`endif
  logic         start;
  logic         stop;
  logic         periodic;
  logic [W-1:0] preset;
  logic [W-1:0] count;
  logic         busy;
  logic         running;
  logic         done;

  modport master (
`ifdef CNT_GATE_EN
    output gate,
`endif
    output start, stop, periodic, preset,
    input  count, busy, running, done
  );

  modport slave (
`ifdef CNT_GATE_EN
    input  gate,
`endif
    input  start, stop, periodic, preset,
    output count, busy, running, done
  );

endinterface

// File: rtl/cnt161_slice.sv
// One 4-bit synchronous binary counter slice with 161 semantics:
// async clear, synchronous active-low parallel load, CEP/CET enables, ripple TC.
module cnt161_slice
  import cnt161_pkg::*;
(
  input  logic               Clk,
  input  logic               MR,
  input  logic               CEP,
  input  logic               CET,
  input  logic               PE,
  input  logic [SLICE_W-1:0] D,
  output logic [SLICE_W-1:0] Q,
  output logic               TC
);

  logic [SLICE_W-1:0] q_q;
  logic [SLICE_W-1:0] q_d;

  always_comb begin
    q_d = q_q;
    if (!PE) begin
      q_d = D;
    end else if (CEP && CET) begin
      q_d = q_q + 4'd1;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge Clk or negedge MR) begin
    if (!MR) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign Q  = q_q;
  assign TC = CET && (&q_q);

endmodule

// File: rtl/cnt161_timer_ctrl.sv
// Timer sequencer driving a chain of cnt161_slice counters (one-shot / periodic, hold, retrigger).
// Optional CNT_GATE_EN adds a gate input that pauses counting while in RUN.
module cnt161_timer_ctrl
  import cnt161_pkg::*;
#(
  parameter int STAGES = 2
)(
  input  logic                Clk,
  input  logic                MR,
  cnt161_timer_ctrl_if.slave  bus
);

  localparam int W = SLICE_W * STAGES;

  state_e       state_q, state_d;
  logic         mode_q, mode_d;
  logic         done_q, done_d;

  logic         gate;
  logic         run_en;
  logic         all_ones;
  logic         cep;
  logic         pe_n;
  logic         tc;
  logic         term;
  logic [W-1:0] q_chain;
  logic [STAGES-1:0] cet_s;
  logic [STAGES-1:0] tc_s;

`ifdef CNT_GATE_EN
  assign gate = bus.gate;
`else
  assign gate = 1'b1;
`endif

  // Terminal detect is split from CEP so a one-shot can suppress CEP on all-ones
  // without a combinational loop through the ripple TC.
  assign all_ones = &q_chain;
  assign run_en   = (state_q == RUN) && gate;
  assign cep      = run_en && (mode_q || !all_ones);
  assign term     = mode_q ? tc : (run_en && all_ones);

  assign cet_s[0] = cep;
  for (genvar i = 0; i < STAGES; i++) begin : g_slice
    if (i > 0) begin : g_cet
      assign cet_s[i] = tc_s[i-1];
    end
    cnt161_slice u_slice (
      .Clk (Clk),
      .MR  (MR),
      .CEP (cep),
      .CET (cet_s[i]),
      .PE  (pe_n),
      .D   (bus.preset[i*SLICE_W +: SLICE_W]),
      .Q   (q_chain[i*SLICE_W +: SLICE_W]),
      .TC  (tc_s[i])
    );
  end
  assign tc = tc_s[STAGES-1];

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    done_d  = 1'b0;
    pe_n    = 1'b1;
    case (state_q)
      IDLE: begin
        if (bus.start && !bus.stop) state_d = LOAD;
      end
      LOAD: begin
        pe_n    = 1'b0;
        mode_d  = bus.periodic;
        state_d = RUN;
      end
      RUN: begin
        done_d = term;
        if (term && mode_q) pe_n = 1'b0;
        if (bus.stop) begin
          state_d = (term && !mode_q) ? IDLE : HOLD;
        end else if (bus.start) begin
          state_d = LOAD;
        end else if (term && !mode_q) begin
          state_d = IDLE;
        end
      end
      HOLD: begin
        if (bus.stop)       state_d = IDLE;
        else if (bus.start) state_d = RUN;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge MR) begin
    if (!MR) begin
      state_q <= IDLE;
      mode_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      done_q  <= done_d;
    end
  end

  assign bus.count   = q_chain;
  assign bus.busy    = (state_q != IDLE);
  assign bus.running = (state_q == RUN);
  assign bus.done    = done_q;

endmodule

// File: tb/tb_cnt161_timer_ctrl.sv
// Directed self-checking bench for cnt161_timer_ctrl (STAGES=2, W=8).
module tb_cnt161_timer_ctrl;

  logic Clk = 1'b0;
  logic MR  = 1'b0;
  int   total = 0;
  int   bad   = 0;

  cnt161_timer_ctrl_if #(.W(8)) bus ();

  cnt161_timer_ctrl #(.STAGES(2)) dut (
    .Clk (Clk),
    .MR  (MR),
    .bus (bus)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Inputs set before step() are sampled at the next rising edge; outputs read 1ns later.
  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Pulse start for one edge (IDLE->LOAD), then one more edge so Q = preset.
  task automatic launch(input logic [7:0] p, input logic per);
    bus.preset   = p;
    bus.periodic = per;
    bus.start    = 1'b1;
    step();
    check("launch_load_busy", bus.busy, 1'b1);
    bus.start = 1'b0;
    step();
    check("launch_first_q", bus.count, p);
  endtask

  initial begin
`ifdef CNT_GATE_EN
    bus.gate     = 1'b1;
`endif
    bus.start    = 1'b0;
    bus.stop     = 1'b0;
    bus.periodic = 1'b0;
    bus.preset   = 8'h00;
    #12;
    check("rst_count", bus.count, 8'h00);
    check("rst_busy", bus.busy, 1'b0);
    check("rst_running", bus.running, 1'b0);
    check("rst_done", bus.done, 1'b0);
    MR = 1'b1;
    steps(2);
    check("idle_no_count", bus.count, 8'h00);

    // One-shot 0xF6: counts F6..FF, done one cycle after FF, busy drops with it.
    launch(8'hF6, 1'b0);
    for (int k = 1; k < 10; k++) begin
      step();
      check("os_count", bus.count, 8'hF6 + k[7:0]);
      check("os_done_low", bus.done, 1'b0);
    end
    check("os_busy_at_ff", bus.busy, 1'b1);
    step();
    check("os_done", bus.done, 1'b1);
    check("os_busy_off", bus.busy, 1'b0);
    check("os_hold_ff", bus.count, 8'hFF);
    step();
    check("os_done_once", bus.done, 1'b0);
    check("os_still_ff", bus.count, 8'hFF);

    // Periodic 0xFC: FC FD FE FF repeating, done when FC reappears.
    launch(8'hFC, 1'b1);
    for (int k = 1; k < 12; k++) begin
      step();
      check("per_count", bus.count, 8'hFC + 8'(k % 4));
      check("per_done", bus.done, (k % 4 == 0) ? 1'b1 : 1'b0);
      check("per_busy", bus.busy, 1'b1);
    end
    // stop on a terminal cycle: reload and done still happen, state goes HOLD.
    bus.stop = 1'b1;
    step();
    check("per_stop_reload", bus.count, 8'hFC);
    check("per_stop_done", bus.done, 1'b1);
    check("per_stop_hold", bus.running, 1'b0);
    check("per_stop_busy", bus.busy, 1'b1);
    step();
    check("per_abort_busy", bus.busy, 1'b0);
    check("per_abort_done", bus.done, 1'b0);
    bus.stop = 1'b0;

    // Hold at 0x80 then resume.
    launch(8'h70, 1'b0);
    steps(15);
    check("hold_pre", bus.count, 8'h7F);
    bus.stop = 1'b1;
    step();
    bus.stop = 1'b0;
    check("hold_enter", bus.count, 8'h80);
    for (int k = 0; k < 5; k++) begin
      step();
      check("hold_frozen", bus.count, 8'h80);
      check("hold_not_run", bus.running, 1'b0);
      check("hold_no_done", bus.done, 1'b0);
    end
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    check("resume_run", bus.running, 1'b1);
    check("resume_val", bus.count, 8'h80);
    step();
    check("resume_inc", bus.count, 8'h81);

    // Abort: stop in RUN -> HOLD, stop again -> IDLE with no done.
    bus.stop = 1'b1;
    step();
    check("abort_hold", bus.count, 8'h82);
    check("abort_hold_busy", bus.busy, 1'b1);
    step();
    check("abort_idle", bus.busy, 1'b0);
    check("abort_no_done", bus.done, 1'b0);
    bus.stop = 1'b0;
    step();
    check("abort_no_done2", bus.done, 1'b0);
    check("abort_frozen", bus.count, 8'h82);

    // Async reset mid-RUN at 0x3A.
    launch(8'h30, 1'b0);
    steps(10);
    check("rst_pre", bus.count, 8'h3A);
    MR = 1'b0;
    #1;
    check("rst_async_count", bus.count, 8'h00);
    check("rst_async_busy", bus.busy, 1'b0);
    #1;
    MR = 1'b1;
    steps(3);
    check("rst_after_count", bus.count, 8'h00);
    check("rst_after_busy", bus.busy, 1'b0);

    // start and stop together in IDLE: no effect.
    bus.start = 1'b1;
    bus.stop  = 1'b1;
    step();
    check("ss_idle", bus.busy, 1'b0);
    bus.start = 1'b0;
    bus.stop  = 1'b0;

    // Preset 0xFF one-shot: single terminal cycle, done two cycles after LOAD.
    launch(8'hFF, 1'b0);
    check("ff_running", bus.running, 1'b1);
    check("ff_no_done_yet", bus.done, 1'b0);
    step();
    check("ff_done", bus.done, 1'b1);
    check("ff_idle", bus.busy, 1'b0);
    check("ff_hold", bus.count, 8'hFF);

    // Nibble carry 0x0F -> 0x10.
    launch(8'h0E, 1'b0);
    step();
    check("carry_0f", bus.count, 8'h0F);
    step();
    check("carry_10", bus.count, 8'h10);
    step();
    check("carry_11", bus.count, 8'h11);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
